// File: rtl/apb_master_arb.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_arb
// Description : Two-requester round-robin arbiter in front of a single APB
//               master. A granted request runs one SETUP/ACCESS transfer and
//               returns a one-cycle response pulse to its owner. An optional
//               ACCESS-phase timeout aborts transfers whose slave never
//               raises pready.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_arb #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_write,
    input  logic [15:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic [1:0]  req_ready,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [7:0]  paddr,
    output logic [31:0] pwdata,
    input  logic        pready,
    input  logic [31:0] prdata
);

    // Counter only needs to reach TIMEOUT-1; keep at least one bit so the
    // design still elaborates when the timeout is disabled.
    localparam int              c_CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CW-1:0] c_TO_LAST = c_CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit              c_TO_EN   = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_last;      // requester granted most recently
    logic [c_CW-1:0]   r_cnt;       // ACCESS cycles already spent without pready
    logic              r_psel;
    logic              r_penable;
    logic              r_busy;
    logic              r_pwrite;
    logic [7:0]        r_paddr;
    logic [31:0]       r_pwdata;
    logic [1:0]        r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;

    logic [1:0]        w_grant;
    logic              w_pick1;
    logic              w_win;
    logic              w_accept;
    logic              w_expire;
    logic              w_done;

    // Round-robin pick: requester 1 wins if it is alone, or if both ask and
    // requester 0 was the last one served.
    always_comb begin
        w_pick1  = req_valid[1] & (~req_valid[0] | ~r_last);
        w_grant  = {w_pick1, req_valid[0] & ~w_pick1};
        w_win    = w_pick1;
        w_expire = c_TO_EN && (r_cnt == c_TO_LAST);
        w_done   = (r_state == S_ACCESS) && (pready || w_expire);
    end

    // Next-state decode and the combinational grant handshake.
    always_comb begin
        w_next    = r_state;
        req_ready = 2'b00;
        w_accept  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (reset) begin
                    req_ready = w_grant;
                end
                w_accept = |w_grant;
                if (|w_grant) begin
                    w_next = S_SETUP;
                end
            end
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: begin
                if (w_done) begin
                    w_next = S_IDLE;
                end
            end
            default:  w_next = S_IDLE;
        endcase
    end

    // State, arbitration pointer and registered APB control signals.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_last    <= 1'b1;
            r_cnt     <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_psel    <= (w_next != S_IDLE);
            r_penable <= (w_next == S_ACCESS);
            r_busy    <= (w_next != S_IDLE);
            if (w_accept) begin
                r_last <= w_win;
            end
            if ((r_state == S_ACCESS) && !w_done) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // Request capture on accept and response generation on completion.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 2'b00;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pwrite <= req_write[w_win];
                r_paddr  <= w_win ? req_addr[15:8] : req_addr[7:0];
                r_pwdata <= req_write[w_win] ? (w_win ? req_wdata[63:32] : req_wdata[31:0]) : 32'h0;
            end
            // pready wins a tie with the expiring timeout.
            r_rsp_valid <= w_done ? (r_last ? 2'b10 : 2'b01) : 2'b00;
            r_rsp_err   <= w_done & ~pready;
            r_rsp_rdata <= (w_done && pready && !r_pwrite) ? prdata : 32'h0;
        end
    end

    assign psel      = r_psel;
    assign penable   = r_penable;
    assign busy      = r_busy;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_arb
// Description : Self-checking bench for apb_master_arb. Each scenario task
//               drives stimulus and compares against a transaction-level
//               reference model (round-robin pointer, transfer length from
//               wait states and timeout, expected response contents).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_arb;

    localparam int c_TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;

    int n_vec = 0;
    int n_err = 0;
    int m_last = 1;   // model: requester served last (1 => requester 0 has priority)

    always #5 clk = ~clk;

    apb_master_arb #(.TIMEOUT(c_TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pready(pready), .prdata(prdata)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req;
        req_write = 2'($urandom);
        req_addr  = 16'($urandom);
        req_wdata = {$urandom, $urandom};
    endtask

    // One full transfer from the accepting IDLE cycle to the response cycle.
    // Returns positioned in the response cycle so the next call can accept there.
    task automatic run_xfer(input logic [1:0] vmask, input int waits, input logic [31:0] rd,
                            input bit keep, input string tag);
        int          w;
        int          k;
        bit          ok;
        bit          done;
        logic [1:0]  eg;
        logic [7:0]  ea;
        logic        ew;
        logic [31:0] ed;
        logic [31:0] er;
        req_valid = vmask;
        #1;
        w  = (vmask == 2'b11) ? (1 - m_last) : (vmask[1] ? 1 : 0);
        eg = (w == 1) ? 2'b10 : 2'b01;
        ew = req_write[w];
        ea = (w == 1) ? req_addr[15:8] : req_addr[7:0];
        ed = ew ? ((w == 1) ? req_wdata[63:32] : req_wdata[31:0]) : 32'h0;
        n_vec++;
        if (req_ready !== eg) begin
            n_err++;
            $display("FAIL %s grant: got=%b exp=%b", tag, req_ready, eg);
        end
        tick;
        m_last = w;
        if (!keep) req_valid[w] = 1'b0;
        pready = 1'b1;                 // must be ignored during SETUP
        prdata = $urandom;
        #1;
        n_vec++;
        if ({psel, penable, pwrite, paddr, pwdata, busy, req_ready, rsp_valid} !==
            {1'b1, 1'b0, ew, ea, ed, 1'b1, 2'b00, 2'b00}) begin
            n_err++;
            $display("FAIL %s setup: got psel=%b pen=%b pw=%b pa=%h pd=%h busy=%b rdy=%b rv=%b exp pw=%b pa=%h pd=%h",
                     tag, psel, penable, pwrite, paddr, pwdata, busy, req_ready, rsp_valid, ew, ea, ed);
        end
        tick;
        k    = 0;
        ok   = 1'b0;
        done = 1'b0;
        while (!done) begin
            ok     = (k == waits);
            pready = ok;
            prdata = ok ? rd : $urandom;
            #1;
            n_vec++;
            if ({psel, penable, pwrite, paddr, pwdata, busy, req_ready, rsp_valid} !==
                {1'b1, 1'b1, ew, ea, ed, 1'b1, 2'b00, 2'b00}) begin
                n_err++;
                $display("FAIL %s access%0d: got psel=%b pen=%b pw=%b pa=%h pd=%h busy=%b rdy=%b rv=%b exp pw=%b pa=%h pd=%h",
                         tag, k, psel, penable, pwrite, paddr, pwdata, busy, req_ready, rsp_valid, ew, ea, ed);
            end
            done = ok || (k + 1 == c_TO);
            tick;
            k++;
        end
        pready = 1'b0;
        prdata = $urandom;
        #1;
        er = (ok && !ew) ? rd : 32'h0;
        n_vec++;
        if ({psel, penable, busy, rsp_valid, rsp_err, rsp_rdata} !== {1'b0, 1'b0, 1'b0, eg, ~ok, er}) begin
            n_err++;
            $display("FAIL %s response: got psel=%b pen=%b busy=%b rv=%b err=%b rd=%h exp rv=%b err=%b rd=%h",
                     tag, psel, penable, busy, rsp_valid, rsp_err, rsp_rdata, eg, ~ok, er);
        end
    endtask

    task automatic test_reset;
        reset     = 1'b0;
        req_valid = 2'b11;
        pready    = 1'b1;
        prdata    = $urandom;
        set_req;
        tick;
        tick;
        n_vec++;
        if ({psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, busy, req_ready} !== '0) begin
            n_err++;
            $display("FAIL reset outputs: got psel=%b pen=%b pw=%b pa=%h pd=%h rv=%b rd=%h err=%b busy=%b rdy=%b exp all 0",
                     psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, busy, req_ready);
        end
        reset     = 1'b1;
        req_valid = 2'b00;
        pready    = 1'b0;
        m_last    = 1;
        tick;
    endtask

    task automatic test_single_write;
        req_write = 2'b01;
        req_addr  = 16'h0010;
        req_wdata = {32'h0, 32'hDEADBEEF};
        run_xfer(2'b01, 0, 32'h0, 1'b0, "single_write");
        req_valid = 2'b00;
        tick;
    endtask

    task automatic test_read_wait;
        req_write = 2'b00;
        req_addr  = 16'h2400;
        req_wdata = {$urandom, $urandom};
        run_xfer(2'b10, 2, 32'h12345678, 1'b0, "read_wait");
        req_valid = 2'b00;
        tick;
    endtask

    task automatic test_contention;
        reset = 1'b0;
        tick;
        reset  = 1'b1;
        m_last = 1;
        for (int i = 0; i < 4; i++) begin
            set_req;
            run_xfer(2'b11, 0, $urandom, 1'b1, "contention");
        end
        req_valid = 2'b00;
        tick;
    endtask

    task automatic test_timeout;
        set_req;
        run_xfer(2'b01, 99, $urandom, 1'b0, "timeout");
        req_valid = 2'b00;
        tick;
        set_req;
        req_write = 2'b00;
        run_xfer(2'b10, c_TO - 1, $urandom, 1'b0, "timeout_tie");
        req_valid = 2'b00;
        tick;
    endtask

    task automatic test_reset_mid;
        set_req;
        req_valid = 2'b01;
        tick;
        req_valid = 2'b00;
        pready    = 1'b0;
        tick;
        tick;
        n_vec++;
        if ({psel, penable} !== 2'b11) begin
            n_err++;
            $display("FAIL reset_mid pre: got psel=%b pen=%b exp 1 1", psel, penable);
        end
        reset     = 1'b0;
        req_valid = 2'b11;
        pready    = 1'b1;
        prdata    = $urandom;
        #1;
        n_vec++;
        if (req_ready !== 2'b00) begin
            n_err++;
            $display("FAIL reset_mid ready: got=%b exp=00", req_ready);
        end
        tick;
        n_vec++;
        if ({psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_mid outputs: got psel=%b pen=%b pw=%b pa=%h pd=%h rv=%b rd=%h err=%b busy=%b exp all 0",
                     psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, busy);
        end
        reset     = 1'b1;
        req_valid = 2'b00;
        pready    = 1'b0;
        m_last    = 1;
        tick;
        n_vec++;
        if ({rsp_valid, psel} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_mid late pulse: got rv=%b psel=%b exp 00 0", rsp_valid, psel);
        end
        set_req;
        run_xfer(2'b10, 0, $urandom, 1'b0, "reset_mid_req1");
        req_valid = 2'b00;
        tick;
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            set_req;
            run_xfer(2'($urandom_range(1, 3)), int'($urandom_range(0, 5)), $urandom, 1'b0, "random");
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 2'b00;
                tick;
                n_vec++;
                if ({req_ready, psel, rsp_valid} !== 5'b0) begin
                    n_err++;
                    $display("FAIL random idle: got rdy=%b psel=%b rv=%b exp 00 0 00", req_ready, psel, rsp_valid);
                end
            end
        end
        req_valid = 2'b00;
        tick;
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 2'b00;
        req_write = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        pready    = 1'b0;
        prdata    = '0;
        test_reset;
        test_contention;
        test_single_write;
        test_read_wait;
        test_timeout;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
